tx_module: RTL and testbench



---
 rtl/tx_module_if.sv | 26 ++
 rtl/tx_module.sv | 132 +++++++++++++
 tb/tb_tx_module.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_module_if.sv
// Byte-in / serial-out handshake bundle between a byte producer and the UART transmitter.
`timescale 1ns/1ps

interface tx_module_if;
  logic       i_tx_valid;
  logic [7:0] i_tx_byte;
  logic       o_tx_active;
  logic       o_tx_serial;
  logic       o_done;

  modport master (
    output i_tx_valid,
    output i_tx_byte,
    input  o_tx_active,
    input  o_tx_serial,
    input  o_done
  );

  modport slave (
    input  i_tx_valid,
    input  i_tx_byte,
    output o_tx_active,
    output o_tx_serial,
    output o_done
  );
endinterface

// File: rtl/tx_module.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// Each bit lasts BIT_CLK_PER clocks; o_done pulses one cycle at frame end.
`timescale 1ns/1ps

module tx_module #(
  parameter int unsigned BIT_CLK_PER = 868
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  tx_module_if.slave  bus
);

  localparam int unsigned CNT_W = (BIT_CLK_PER > 2) ? $clog2(BIT_CLK_PER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLK_PER - 1);
  localparam logic [2:0]       IDX_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       idx_q,    idx_d;
  logic [7:0]       shift_q,  shift_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q,   done_d;

  logic             bit_end;
  logic [2:0]       idx_nxt;

  assign bit_end = (cnt_q == CNT_LAST);
  assign idx_nxt = idx_q + 3'd1;

  // Next-state and next-output computation; outputs leave the block through registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (bus.i_tx_valid) begin
          shift_d  = bus.i_tx_byte;
          active_d = 1'b1;
          serial_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          cnt_d    = '0;
          idx_d    = 3'd0;
          serial_d = shift_q[0];
          state_d  = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            serial_d = 1'b1;
            state_d  = ST_STOP;
          end else begin
            idx_d    = idx_nxt;
            serial_d = shift_q[idx_nxt];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Reset aborts any frame in flight and parks the line high.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_tx_serial = serial_q;
  assign bus.o_tx_active = active_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_tx_module.sv
// Self-checking bench for tx_module: a slow (868 clk/bit) and a fast (4 clk/bit) instance
// compared cycle by cycle against a frame model built from the byte being sent.
`timescale 1ns/1ps

module tb_tx_module;

  localparam int BIG_P   = 868;
  localparam int SMALL_P = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tx_module_if big_if ();
  tx_module_if small_if ();

  tx_module #(.BIT_CLK_PER(BIG_P)) u_big (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (big_if.slave)
  );

  tx_module #(.BIT_CLK_PER(SMALL_P)) u_small (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (small_if.slave)
  );

  // {done, active, serial} of the selected instance (0 = slow, 1 = fast)
  function automatic logic [2:0] obs(input bit sel);
    if (sel) return {small_if.o_done, small_if.o_tx_active, small_if.o_tx_serial};
    return {big_if.o_done, big_if.o_tx_active, big_if.o_tx_serial};
  endfunction

  task automatic drive_valid(input bit sel, input logic v);
    if (sel) small_if.i_tx_valid = v;
    else     big_if.i_tx_valid   = v;
  endtask

  task automatic drive_byte(input bit sel, input logic [7:0] b);
    if (sel) small_if.i_tx_byte = b;
    else     big_if.i_tx_byte   = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level during frame slot k: 0 start, 1..8 data LSB first, 9 stop
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    logic [7:0] v;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    v = b >> (k - 1);
    return v[0];
  endfunction

  // Present byte with valid; returns just after the acceptance edge
  task automatic send(input bit sel, input logic [7:0] b);
    drive_byte(sel, b);
    drive_valid(sel, 1'b1);
    step();
  endtask

  task automatic check_idle(input bit sel, input int n, input string name);
    int bad = 0;
    logic [2:0] o;
    logic [2:0] last = 3'b001;
    for (int i = 0; i < n; i++) begin
      o = obs(sel);
      if (o !== 3'b001) begin
        bad++;
        last = o;
      end
      step();
    end
    if (n > 0) begin
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s idle: %0d bad cycles, got {done,active,serial}=%b want 001", name, bad, last);
      end
    end
  endtask

  // Entered just after acceptance edge T0; leaves just after edge T0+10p (done cycle)
  task automatic check_frame(input bit sel, input int p, input logic [7:0] b,
                             input int drop_at, input int change_at, input string name);
    int bad = 0;
    logic [2:0] o;
    logic [2:0] want;
    logic [2:0] got_first = '0;
    logic [2:0] want_first = '0;
    for (int t = 0; t < 10 * p; t++) begin
      if (t % p == 0) bad = 0;
      o    = obs(sel);
      want = {1'b0, 1'b1, frame_bit(b, t / p)};
      if (o !== want) begin
        if (bad == 0) begin
          got_first  = o;
          want_first = want;
        end
        bad++;
      end
      if (t % p == p - 1) begin
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL %s slot%0d: %0d bad cycles, got {done,active,serial}=%b want %b",
                   name, t / p, bad, got_first, want_first);
        end
      end
      if (t == drop_at)   drive_valid(sel, 1'b0);
      if (t == change_at) drive_byte(sel, ~b);
      step();
    end
    o = obs(sel);
    checks++;
    if (o !== 3'b101) begin
      errors++;
      $display("FAIL %s done_cycle: got {done,active,serial}=%b want 101", name, o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs(1'b0), obs(1'b1)} !== 6'b001_001) begin
      errors++;
      $display("FAIL reset_values: got %b want 001001", {obs(1'b0), obs(1'b1)});
    end
    #9 rst_n = 1'b1;
    step();
    check_idle(1'b0, 6, "reset_big");
    check_idle(1'b1, 6, "reset_small");
  endtask

  task automatic test_frame_6e();
    send(1'b0, 8'h6E);
    check_frame(1'b0, BIG_P, 8'h6E, 4, -1, "frame_6e");
  endtask

  // Valid raised in the done cycle; accepted on the very next edge
  task automatic test_back_to_back();
    drive_byte(1'b0, 8'h7F);
    drive_valid(1'b0, 1'b1);
    step();
    check_frame(1'b0, BIG_P, 8'h7F, 0, -1, "b2b_7f");
    step();
    check_idle(1'b0, 4, "b2b_after");
  endtask

  task automatic test_byte_change();
    send(1'b0, 8'hA5);
    check_frame(1'b0, BIG_P, 8'hA5, 0, 2 * BIG_P + 5, "byte_change");
    step();
    check_idle(1'b0, 4, "byte_change_after");
  endtask

  task automatic test_reset_mid_data();
    send(1'b0, 8'hC3);
    drive_valid(1'b0, 1'b0);
    for (int i = 0; i < 3 * BIG_P + 17; i++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs(1'b0) !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_data: got {done,active,serial}=%b want 001", obs(1'b0));
    end
    #9 rst_n = 1'b1;
    check_idle(1'b0, 25, "post_abort");
    send(1'b0, 8'h3C);
    check_frame(1'b0, BIG_P, 8'h3C, 0, -1, "fresh_after_abort");
    step();
    check_idle(1'b0, 4, "fresh_after");
  endtask

  // Valid held high: frames separated by exactly the done cycle
  task automatic test_continuous();
    logic [7:0] b;
    logic [7:0] nb;
    b = 8'($urandom);
    send(1'b1, b);
    for (int f = 0; f < 5; f++) begin
      nb = 8'($urandom);
      check_frame(1'b1, SMALL_P, b, -1, -1, "continuous");
      if (f == 4) drive_valid(1'b1, 1'b0);
      drive_byte(1'b1, nb);
      step();
      b = nb;
    end
    check_idle(1'b1, 6, "continuous_after");
  endtask

  task automatic test_random();
    logic [7:0] b;
    int gap;
    int hold;
    int chg;
    for (int i = 0; i < 30; i++) begin
      gap  = int'($urandom_range(0, 3));
      b    = 8'($urandom);
      hold = int'($urandom_range(0, 12));
      chg  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10 * SMALL_P - 1)) : -1;
      check_idle(1'b1, gap, "random_gap");
      send(1'b1, b);
      check_frame(1'b1, SMALL_P, b, hold, chg, "random");
      step();
    end
    check_idle(1'b1, 4, "random_after");
  endtask

  initial begin
    big_if.i_tx_valid   = 1'b0;
    big_if.i_tx_byte    = 8'h00;
    small_if.i_tx_valid = 1'b0;
    small_if.i_tx_byte  = 8'h00;
    test_reset();
    test_frame_6e();
    test_back_to_back();
    test_byte_change();
    test_reset_mid_data();
    test_continuous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
